fm_streamer: RTL
================

FM_STREAMER -- requirements
Module: fm_streamer

Interface
REQ-001 Parameter FM_SIZE, default 4: unpadded feature-map side length in pixels.
REQ-002 Parameter PADDING, default 1: zero rows/columns inserted on each side.
REQ-003 Parameter DATA_WIDTH, default 16: signed pixel width held in memory.
REQ-004 Parameter ADDR_WIDTH, default 16: memory address width.
REQ-005 Parameter A_WIDTH, default `A_DSP_WIDTH: output pixel width matching the PE A-port.
REQ-006 i_clk  input  1  single clock; all logic rising-edge.
REQ-007 i_rst_n  input  1  reset, synchronous, active-low.
REQ-008 i_start  input  1  one-cycle request to stream one feature map.
REQ-009 i_base_addr  input  ADDR_WIDTH  address of pixel (0,0), sampled with i_start.
REQ-010 o_rd_en  output  1  memory read strobe.
REQ-011 o_rd_addr  output  ADDR_WIDTH  memory read address.
REQ-012 i_rd_data  input  DATA_WIDTH  signed read data, valid exactly 1 cycle after o_rd_en.
REQ-013 o_DataFM  output  A_WIDTH  signed padded pixel stream toward the PE.
REQ-014 o_en  output  1  pixel valid; stays high for the whole frame.
REQ-015 o_busy  output  1  frame in progress.
REQ-016 o_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-017 PS = FM_SIZE+2*PADDING; one frame = PS*PS output pixels in raster order (row-major, column fastest).
REQ-018 FSM states IDLE, STREAM, FLUSH; IDLE->STREAM on i_start; STREAM->FLUSH after issuing position (PS-1,PS-1); FLUSH->IDLE after one cycle.
REQ-019 i_start is ignored while o_busy=1; i_base_addr is latched only on an accepted start.
REQ-020 In STREAM one position (row r, col c) is issued per cycle, no gaps, no backpressure.
REQ-021 Position is interior when PADDING<=r<PADDING+FM_SIZE and PADDING<=c<PADDING+FM_SIZE; otherwise it is padding.
REQ-022 Interior position: o_rd_en=1, o_rd_addr=base+(r-PADDING)*FM_SIZE+(c-PADDING), generated by a running incrementing address counter (no multiplier).
REQ-023 Padding position: o_rd_en=0, o_rd_addr holds its last value.
REQ-024 Interior/padding flag and issue-valid are pipelined one cycle to align with i_rd_data.
REQ-025 o_DataFM/o_en are registered: position issued in cycle t appears at cycle t+2; interior -> sign-extended i_rd_data, padding -> 0.
REQ-026 Accepted start at cycle 0: first issue cycle 1, o_en high cycles 3 .. PS*PS+2 contiguously, o_done=1 at cycle PS*PS+3 only.
REQ-027 o_busy=1 from cycle 1 through the o_done cycle inclusive; a new i_start is accepted in the cycle after o_done.
REQ-028 o_en is low outside the frame window; o_DataFM is 0 whenever o_en=0.
REQ-029 PADDING=0: no padding positions; every issue is a read; frame is FM_SIZE*FM_SIZE cycles.
REQ-030 Address counter wraps modulo 2^ADDR_WIDTH without error.
REQ-031 Total reads per frame = FM_SIZE*FM_SIZE exactly.

Reset
REQ-032 While i_rst_n=0 at a rising edge: state IDLE, counters 0, o_rd_en=0, o_rd_addr=0, o_DataFM=0, o_en=0, o_busy=0, o_done=0.
REQ-033 Reset mid-frame aborts the frame: all outputs at reset values from the next edge; no o_done is generated for the aborted frame.
REQ-034 i_start asserted together with i_rst_n=0 is discarded.

Verification
REQ-035 FM_SIZE=4, PADDING=1, base=0x10, memory[k]=k+1: 36 contiguous o_en cycles; rows 0 and 5 and columns 0 and 5 are 0; interior row 1 = 0x11,0x12,0x13,0x14 (memory[0x10..0x13] = 17,18,19,20); 16 reads at 0x10..0x1F in order.
REQ-036 Same config, start at cycle 0: o_en first high cycle 3, last high cycle 38, o_done at cycle 39, o_busy cycles 1..39.
REQ-037 Memory word 0x8000 (DATA_WIDTH=16) -> o_DataFM = sign-extended -32768 across A_WIDTH bits.
REQ-038 i_start pulsed at cycles 5 and 20 during a frame -> ignored; back-to-back start in the cycle after o_done -> second frame identical to first.
REQ-039 i_rst_n low for one cycle at output pixel 10 -> o_en, o_busy low next edge, no o_done; fresh start then yields a complete correct 36-pixel frame.
REQ-040 PADDING=0, FM_SIZE=3, base=0xFFFE, ADDR_WIDTH=16 -> 9 reads at 0xFFFE,0xFFFF,0x0000..0x0006, no zero pixels.

Source files
------------

// File: rtl/fm_streamer.sv
// ---------------------------------------------------------------------------
// fm_streamer
//   Streams one zero-padded feature map toward a PE A-port. The unpadded map
//   (FM_SIZE x FM_SIZE signed words) is read from memory starting at a base
//   address. The padded frame (PS x PS, PS = FM_SIZE + 2*PADDING) is emitted
//   in raster order, one pixel per cycle, with zeros on the padding ring.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      one-cycle frame request (ignored while o_busy)
//   i_base_addr  address of pixel (0,0), latched on an accepted start
//   o_rd_en      memory read strobe (interior positions only)
//   o_rd_addr    memory read address (holds across padding positions)
//   i_rd_data    signed read data, valid one cycle after o_rd_en
//   o_DataFM     sign-extended padded pixel, 0 when o_en is low
//   o_en         pixel valid, contiguous for the whole frame
//   o_busy       frame in progress, through the o_done cycle
//   o_done       one-cycle end-of-frame pulse
//   o_dbg_state  FSM state (IDLE=0, STREAM=1, FLUSH=2)
//
// Handshake: i_start is a single-cycle request with no acknowledge; it is
// accepted only when the block is idle and o_busy is low. The output stream
// has no backpressure: every cycle with o_en high carries one pixel.
// ---------------------------------------------------------------------------
`ifndef A_DSP_WIDTH
`define A_DSP_WIDTH 30
`endif

module fm_streamer #(
    parameter int FM_SIZE    = 4,
    parameter int PADDING    = 1,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int A_WIDTH    = `A_DSP_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [A_WIDTH-1:0]    o_DataFM,
    output logic                  o_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_dbg_state
);

    localparam int PS = FM_SIZE + 2 * PADDING;
    localparam int CW = (PS > 1) ? $clog2(PS) : 1;
    localparam logic [CW-1:0] LAST = CW'(PS - 1);
    // Position (0,0) is interior only when there is no padding ring.
    localparam logic START_INT = (PADDING == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    state_e                state_q;
    logic [CW-1:0]         row_q;
    logic [CW-1:0]         col_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;   // next interior address to read
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_en_q;
    logic                  v1_q;         // issue-valid, aligned with i_rd_data
    logic                  int1_q;       // interior flag, aligned with i_rd_data
    logic                  en_q;
    logic [A_WIDTH-1:0]    data_q;
    logic                  busy_q;
    logic                  done_q;

    logic [CW-1:0]         nxt_row_d;
    logic [CW-1:0]         nxt_col_d;
    logic                  nxt_int_d;
    logic                  last_pos_d;
    logic                  accept_d;

    function automatic logic is_interior(input logic [CW-1:0] r, input logic [CW-1:0] c);
        int ri;
        int ci;
        ri = int'(r);
        ci = int'(c);
        return (ri >= PADDING) && (ri < PADDING + FM_SIZE) &&
               (ci >= PADDING) && (ci < PADDING + FM_SIZE);
    endfunction

    always_comb begin
        nxt_row_d  = row_q;
        nxt_col_d  = col_q + CW'(1);
        last_pos_d = (row_q == LAST) && (col_q == LAST);
        if (col_q == LAST) begin
            nxt_col_d = '0;
            nxt_row_d = row_q + CW'(1);
        end
        nxt_int_d  = is_interior(nxt_row_d, nxt_col_d);
        accept_d   = (state_q == IDLE) && !busy_q && i_start;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            addr_cnt_q <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            v1_q       <= 1'b0;
            int1_q     <= 1'b0;
            en_q       <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Issue stage -> data stage: rd_en_q is high exactly on interior issues.
            v1_q   <= (state_q == STREAM);
            int1_q <= rd_en_q;

            // Output stage.
            en_q   <= v1_q;
            data_q <= (v1_q && int1_q) ? A_WIDTH'($signed(i_rd_data)) : '0;
            // Last pixel is on the output and nothing follows it.
            done_q <= en_q && !v1_q;

            if (accept_d) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    rd_en_q <= 1'b0;
                    if (accept_d) begin
                        state_q <= STREAM;
                        row_q   <= '0;
                        col_q   <= '0;
                        if (START_INT) begin
                            rd_en_q    <= 1'b1;
                            rd_addr_q  <= i_base_addr;
                            addr_cnt_q <= i_base_addr + ADDR_WIDTH'(1);
                        end else begin
                            addr_cnt_q <= i_base_addr;
                        end
                    end
                end
                STREAM: begin
                    if (last_pos_d) begin
                        state_q <= FLUSH;
                        rd_en_q <= 1'b0;
                    end else begin
                        row_q <= nxt_row_d;
                        col_q <= nxt_col_d;
                        if (nxt_int_d) begin
                            rd_en_q    <= 1'b1;
                            rd_addr_q  <= addr_cnt_q;
                            addr_cnt_q <= addr_cnt_q + ADDR_WIDTH'(1);
                        end else begin
                            rd_en_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_en     = rd_en_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_DataFM    = data_q;
    assign o_en        = en_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_dbg_state = state_q;

endmodule
